// File: rtl/clock_rate_ctrl_pkg.sv
// Shared constants and FSM encoding for the audio clock-rate controller.
package clock_rate_ctrl_pkg;
  localparam int unsigned CRC_W      = 32;
  localparam int unsigned DIV_CYCLES = CRC_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_DIVIDE = 2'd2,
    ST_APPLY  = 2'd3
  } state_t;
endpackage

// File: rtl/clock_rate_ctrl_udiv_serial.sv
// Restoring unsigned divider, one quotient bit per cycle; done_o marks the last
// iteration, quotient_o is final from the following cycle until the next start_i.
module udiv_serial #(
  parameter int unsigned W = 32
) (
  input  logic         clock_in,
  input  logic         reset_n,
  input  logic         start_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W:0]   divisor_i,
  output logic         done_o,
  output logic [W-1:0] quotient_o
);
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  logic [W:0]    rem_q, rem_d;
  logic [W:0]    dvs_q, dvs_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic [W+1:0]  trial;
  logic          fits;

  assign done_o     = run_q && (cnt_q == CW'(W - 1));
  assign quotient_o = quo_q;

  always_comb begin
    // Dividend bits shift out of the top of quo_q as quotient bits shift in.
    trial = {rem_q, quo_q[W-1]};
    fits  = (trial >= {1'b0, dvs_q});
    rem_d = rem_q;
    dvs_d = dvs_q;
    quo_d = quo_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start_i) begin
      rem_d = '0;
      dvs_d = divisor_i;
      quo_d = dividend_i;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      rem_d = fits ? (trial[W:0] - dvs_q) : trial[W:0];
      quo_d = {quo_q[W-2:0], fits};
      cnt_d = cnt_q + 1'b1;
      if (done_o) run_d = 1'b0;
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      rem_q <= '0;
      dvs_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end
endmodule

// File: rtl/clock_rate_ctrl.sv
// Validates a rate-change request, divides in/(2*out) serially and loads lim-1
// into the clock divider at a half-period boundary; accepts requests only when idle.
module clock_rate_ctrl
  import clock_rate_ctrl_pkg::*;
#(
  parameter int unsigned W = CRC_W
) (
  input  logic         clock_in,
  input  logic         reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_in_freq,
  input  logic [W-1:0] req_out_freq,
  input  logic         div_wrap,
  output logic [W-1:0] lim,
  output logic         lim_load,
  output logic         div_enable,
  output logic         busy,
  output logic         err
);
  state_t       state_q, state_d;
  logic [W-1:0] in_q, in_d, out_q, out_d, lim_q, lim_d;
  logic         lim_load_q, lim_load_d, en_q, en_d, err_q, err_d;
  logic [W:0]   dbl;
  logic         reject, div_start, div_done;
  logic [W-1:0] quo;

  assign dbl    = {out_q, 1'b0};
  assign reject = (out_q == '0) || ({1'b0, in_q} < dbl);

  udiv_serial #(.W(W)) u_div (
    .clock_in   (clock_in),
    .reset_n    (reset_n),
    .start_i    (div_start),
    .dividend_i (in_q),
    .divisor_i  (dbl),
    .done_o     (div_done),
    .quotient_o (quo)
  );

  always_comb begin
    state_d    = state_q;
    in_d       = in_q;
    out_d      = out_q;
    lim_d      = lim_q;
    lim_load_d = 1'b0;
    en_d       = en_q;
    err_d      = 1'b0;
    div_start  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          in_d    = req_in_freq;
          out_d   = req_out_freq;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (reject) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          div_start = 1'b1;
          state_d   = ST_DIVIDE;
        end
      end
      ST_DIVIDE: begin
        if (div_done) state_d = ST_APPLY;
      end
      ST_APPLY: begin
        // A stopped divider has no wrap to wait for, so the first load goes straight in.
        if (!en_q || div_wrap) begin
          lim_d      = quo - W'(1);
          lim_load_d = 1'b1;
          en_d       = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      in_q       <= '0;
      out_q      <= '0;
      lim_q      <= '0;
      lim_load_q <= 1'b0;
      en_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_q       <= in_d;
      out_q      <= out_d;
      lim_q      <= lim_d;
      lim_load_q <= lim_load_d;
      en_q       <= en_d;
      err_q      <= err_d;
    end
  end

  assign req_ready  = reset_n && (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign lim        = lim_q;
  assign lim_load   = lim_load_q;
  assign div_enable = en_q;
  assign err        = err_q;
endmodule

// File: tb/tb_clock_rate_ctrl.sv
// Randomized bench for clock_rate_ctrl against a cycle-budget reference model.
module tb_clock_rate_ctrl;
  logic        clock_in = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_in_freq = '0;
  logic [31:0] req_out_freq = '0;
  logic        div_wrap = 1'b0;
  logic [31:0] lim;
  logic        lim_load, div_enable, busy, err;

  int checks = 0;
  int errors = 0;
  logic [31:0] lim_m = '0;
  logic        en_m = 1'b0;

  clock_rate_ctrl #(.W(32)) dut (
    .clock_in(clock_in), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_in_freq(req_in_freq), .req_out_freq(req_out_freq), .div_wrap(div_wrap),
    .lim(lim), .lim_load(lim_load), .div_enable(div_enable), .busy(busy), .err(err)
  );

  always #5 clock_in = ~clock_in;

  task automatic tick;
    @(posedge clock_in);
    #1;
  endtask

  function automatic bit wrap_at(int c, int per, int ph);
    return (per == 0) ? 1'b1 : ((c % per) == ph);
  endfunction

  // Leaves the bench in cycle 1 (the cycle after the accepting edge).
  task automatic do_req(input logic [31:0] fin, input logic [31:0] fout, input string nm);
    for (int i = 0; i < 100 && !req_ready; i++) tick;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready_timeout: req_ready=%b want 1", nm, req_ready);
    end
    req_valid = 1'b1; req_in_freq = fin; req_out_freq = fout;
    tick;
    req_valid = 1'b0;
  endtask

  // per=0 holds div_wrap high; otherwise div_wrap is high when cycle%per==ph.
  task automatic run_req(input logic [31:0] fin, input logic [31:0] fout, input int per,
                         input int ph, input bit blk, input string nm);
    logic [63:0] d;
    bit          rej;
    logic [31:0] want;
    int          lexp;
    d    = 64'(fout) * 64'd2;
    rej  = (fout == 0) || (64'(fin) < d);
    want = rej ? lim_m : 32'((64'(fin) / d) - 64'd1);
    lexp = 35;
    if (!rej && en_m) begin
      lexp = 0;
      for (int c = 34; lexp == 0; c++) if (wrap_at(c, per, ph)) lexp = c + 1;
    end
    do_req(fin, fout, nm);
    for (int cyc = 1; cyc <= 200; cyc++) begin
      div_wrap = wrap_at(cyc, per, ph);
      if (blk && cyc >= 3 && cyc <= 8) begin
        req_valid = 1'b1; req_in_freq = $urandom; req_out_freq = 32'd1;
        checks++;
        if (req_ready !== 1'b0) begin
          errors++; $display("FAIL %s ready_in_divide: cyc %0d req_ready=%b want 0", nm, cyc, req_ready);
        end
      end else req_valid = 1'b0;
      if (rej) begin
        if (cyc == 1) begin
          checks++;
          if (err !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL %s check_cycle: err=%b busy=%b want 0 1", nm, err, busy);
          end
        end else begin
          checks++;
          if (err !== 1'b1 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL %s reject: err=%b ready=%b busy=%b want 1 1 0", nm, err, req_ready, busy);
          end
          checks++;
          if (lim !== lim_m || div_enable !== en_m) begin
            errors++; $display("FAIL %s reject_keep: lim=%0d en=%b want %0d %b", nm, lim, div_enable, lim_m, en_m);
          end
          break;
        end
      end else if (cyc < lexp) begin
        checks++;
        if (lim_load !== 1'b0 || lim !== lim_m || busy !== 1'b1 || err !== 1'b0) begin
          errors++;
          $display("FAIL %s wait: cyc %0d load=%b lim=%0d busy=%b err=%b want 0 %0d 1 0",
                   nm, cyc, lim_load, lim, busy, err, lim_m);
        end
      end else begin
        checks++;
        if (lim_load !== 1'b1 || lim !== want || div_enable !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL %s load: cyc %0d load=%b lim=%0d en=%b busy=%b want 1 %0d 1 0",
                   nm, cyc, lim_load, lim, div_enable, busy, want);
        end
        lim_m = want; en_m = 1'b1;
        break;
      end
      tick;
    end
    req_valid = 1'b0;
    tick;
    checks++;
    if (lim_load !== 1'b0 || busy !== 1'b0 || lim !== lim_m) begin
      errors++; $display("FAIL %s after: load=%b busy=%b lim=%0d want 0 0 %0d", nm, lim_load, busy, lim, lim_m);
    end
    div_wrap = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) tick;
    checks++;
    if (lim !== 0 || lim_load !== 0 || div_enable !== 0 || busy !== 0 || err !== 0 || req_ready !== 0) begin
      errors++;
      $display("FAIL reset_vals: lim=%0d load=%b en=%b busy=%b err=%b ready=%b want all 0",
               lim, lim_load, div_enable, busy, err, req_ready);
    end
    reset_n = 1'b1;
    tick;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release: req_ready=%b want 1", req_ready);
    end
    lim_m = '0; en_m = 1'b0;
  endtask

  task automatic test_first_config;
    run_req(32'd12_288_000, 32'd48_000, 17, 5, 1'b0, "first_cfg");
  endtask

  task automatic test_reconfig;
    run_req(32'd50_000_000, 32'd48_000, 17, 5, 1'b0, "reconfig");
  endtask

  task automatic test_reject;
    run_req(32'd12_288_000, 32'd0, 9, 2, 1'b0, "rej_out0");
    run_req(32'd1000, 32'd600, 9, 2, 1'b0, "rej_small");
    run_req(32'hFFFF_FFFF, 32'h8000_0000, 9, 2, 1'b0, "rej_overflow");
    run_req(32'd2, 32'd1, 7, 3, 1'b0, "min_ratio");
  endtask

  task automatic test_wrap_held;
    run_req(32'd24_576_000, 32'd44_100, 0, 0, 1'b0, "wrap_held");
  endtask

  task automatic test_busy_block;
    run_req(32'd12_288_000, 32'd48_000, 11, 0, 1'b1, "busy_block");
  endtask

  task automatic test_random;
    logic [31:0] fin, fout;
    int per, r;
    for (int i = 0; i < 25; i++) begin
      r   = $urandom_range(0, 9);
      fin = $urandom;
      if (r == 0) fout = 32'd0;
      else if (r == 1) fout = (fin >> 1) + 32'($urandom_range(0, 1));
      else fout = 32'($urandom_range(1, 200_000));
      per = $urandom_range(1, 40);
      run_req(fin, fout, per, $urandom_range(0, per - 1), (i % 5) == 0, "random");
    end
  endtask

  task automatic test_reset_mid;
    do_req(32'd50_000_000, 32'd32_000, "reset_mid");
    repeat (9) tick;
    reset_n = 1'b0;
    tick;
    checks++;
    if (busy !== 0 || div_enable !== 0 || lim !== 0 || lim_load !== 0 || err !== 0 || req_ready !== 0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b en=%b lim=%0d load=%b err=%b ready=%b want all 0",
               busy, div_enable, lim, lim_load, err, req_ready);
    end
    reset_n = 1'b1;
    lim_m = '0; en_m = 1'b0;
    tick;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid_release: req_ready=%b want 1", req_ready);
    end
    run_req(32'd12_288_000, 32'd48_000, 13, 4, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset;
    test_first_config;
    test_reconfig;
    test_reject;
    test_wrap_held;
    test_busy_block;
    test_random;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
